// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the 64-bit slave front ends:
//   - HTRANS and HSIZE encodings
//   - data-phase state enum used by the SRAM controller
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no data phase pending
        ST_RD      = 2'd1,  // read data phase
        ST_WR      = 2'd2,  // write data phase, write commits this cycle
        ST_WR_HOLD = 2'd3   // write data phase extended by a read collision
    } ahb_state_e;

endpackage

// File: rtl/ahb_byte_mask.sv
// ----------------------------------------------------------------------------
// ahb_byte_mask
// Combinational byte-lane mask for a 64-bit AHB data bus. The address is
// aligned down to the transfer size; sizes above a dword give an empty mask.
//   i_size  in  3  HSIZE
//   i_addr  in  3  HADDR[2:0]
//   o_mask  out 8  byte lane enables
// ----------------------------------------------------------------------------
module ahb_byte_mask
    import ahb_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [2:0] i_addr,
    output logic [7:0] o_mask
);

    always_comb begin
        o_mask = '0;
        case (i_size)
            HSIZE_BYTE:  o_mask = 8'h01 << i_addr;
            HSIZE_HALF:  o_mask = 8'h03 << {i_addr[2:1], 1'b0};
            HSIZE_WORD:  o_mask = 8'h0F << {i_addr[2], 2'b00};
            HSIZE_DWORD: o_mask = 8'hFF;
            default:     o_mask = '0;
        endcase
    end

endmodule

// File: rtl/ahb_ram_1024x64_ctrl.sv
// ----------------------------------------------------------------------------
// ahb_ram_1024x64_ctrl
// AHB-Lite slave driving a single-port 1024x64 byte-writable SRAM.
// Zero-wait reads and writes; one wait state when a read address phase meets
// a write data phase on the shared RAM port.
//   HCLK/HRESETn           clock, synchronous active-low reset
//   HSEL/HADDR/HTRANS/     AHB-Lite address phase
//   HWRITE/HSIZE/HREADY
//   HWDATA                 write data (data phase)
//   HREADYOUT/HRESP/HRDATA slave response; HRDATA is the RAM output
//   ram_en/ram_we/ram_a/   RAM macro port
//   ram_di/ram_do
// ----------------------------------------------------------------------------
module ahb_ram_1024x64_ctrl
    import ahb_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [63:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [63:0]   HRDATA,
    output logic          ram_en,
    output logic [7:0]    ram_we,
    output logic [AW-4:0] ram_a,
    output logic [63:0]   ram_di,
    input  logic [63:0]   ram_do
);

    ahb_state_e    r_state;
    ahb_state_e    w_state_nxt;
    logic [AW-4:0] r_wr_addr;
    logic [7:0]    r_wr_mask;
    logic [7:0]    w_mask;
    logic          w_accept;
    logic          w_rd_present;
    logic          w_rd_accept;
    logic          w_collide;
    logic          w_unused_bits;

    // High address bits alias; HTRANS[0] only separates NONSEQ from SEQ.
    assign w_unused_bits = ^{HADDR[31:AW], HTRANS[0]};

    ahb_byte_mask u_mask (
        .i_size (HSIZE),
        .i_addr (HADDR[2:0]),
        .o_mask (w_mask)
    );

    assign w_accept     = HSEL & HTRANS[1] & HREADY;
    assign w_rd_accept  = w_accept & ~HWRITE;
    // Collision is judged without HREADY: our own HREADYOUT is what drops it.
    assign w_rd_present = HSEL & HTRANS[1] & ~HWRITE;
    assign w_collide    = (r_state == ST_WR) & w_rd_present;

    assign HREADYOUT = ~w_collide;
    assign HRESP     = 1'b0;
    assign HRDATA    = ram_do;

    always_comb begin
        if (w_collide) begin
            w_state_nxt = ST_WR_HOLD;
        end else if (w_accept) begin
            w_state_nxt = HWRITE ? ST_WR : ST_RD;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_wr_addr <= '0;
            r_wr_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && HWRITE) begin
                r_wr_addr <= HADDR[AW-1:3];
                r_wr_mask <= w_mask;
            end
        end
    end

    // Pending write owns the port; otherwise a read address phase goes
    // straight to the RAM so its data is ready in the next cycle.
    always_comb begin
        ram_en = 1'b0;
        ram_we = '0;
        ram_a  = HADDR[AW-1:3];
        ram_di = HWDATA;
        if (!HRESETn) begin
            ram_en = 1'b0;
        end else if (r_state == ST_WR) begin
            ram_en = 1'b1;
            ram_we = r_wr_mask;
            ram_a  = r_wr_addr;
        end else if (w_rd_accept) begin
            ram_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_ram_1024x64_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ahb_ram_1024x64_ctrl
// Bench for ahb_ram_1024x64_ctrl with a behavioural RAM macro, a pipelined
// AHB master and a read-data scoreboard backed by a reference memory.
// ----------------------------------------------------------------------------
module tb_ahb_ram_1024x64_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [9:0]  ram_a;
    logic [63:0] ram_di;
    logic [63:0] ram_do;

    logic        hready_low = 1'b0;
    logic        ram_clear  = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    assign HREADY = hready_low ? 1'b0 : HREADYOUT;

    ahb_ram_1024x64_ctrl #(.AW(13)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
    );

    // Behavioural SRAM macro: byte writes, registered read data.
    logic [63:0] mem [1024];
    always @(posedge HCLK) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (ram_en) begin
            for (int b = 0; b < 8; b++)
                if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
            ram_do <= mem[ram_a];
        end
    end

    logic [63:0] ref_mem [1024];

    typedef struct {
        bit          vld;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  exp_we;
        bit          chk;
        logic [63:0] exp_rd;
    } tx_t;

    typedef struct {
        logic [63:0] model;
        bit          chk;
        logic [63:0] konst;
    } sb_t;

    tx_t txq[$];
    sb_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Lane mask from the lane range covered by the aligned transfer.
    function automatic logic [7:0] ref_mask(input logic [2:0] sz, input logic [2:0] lo);
        int unsigned n;
        int unsigned base;
        logic [7:0]  m;
        m = '0;
        if (sz > 3) return m;
        n    = 1 << sz;
        base = (int'(lo) / n) * n;
        for (int b = 0; b < 8; b++) m[b] = (b >= base) && (b < base + n);
        return m;
    endfunction

    function automatic tx_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                               input logic [63:0] wd, input logic [7:0] we,
                               input bit c, input logic [63:0] rd);
        tx_t t;
        t.vld = 1'b1; t.wr = wr; t.addr = a; t.size = sz; t.wdata = wd;
        t.exp_we = we; t.chk = c; t.exp_rd = rd;
        return t;
    endfunction

    function automatic tx_t idle_tx();
        tx_t t;
        t = mk(1'b0, '0, '0, '0, '0, 1'b0, '0);
        t.vld = 1'b0;
        return t;
    endfunction

    task automatic drive_idle();
        HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HADDR = '0; HSIZE = '0; HWDATA = '0;
    endtask

    // Pipelined master: runs txq to completion. Entered and left just after a
    // rising edge. Reports wait states and the cycle span first addr -> last read.
    task automatic run_queue(output int stalls, output int span);
        tx_t dp;
        tx_t t;
        sb_t e;
        bit  dp_act;
        bit  dp_first;
        bit  rdy;
        int  i;
        int  budget;
        int  first_cyc;
        int  last_cyc;
        dp = idle_tx(); dp_act = 0; dp_first = 0; i = 0; budget = 0;
        stalls = 0; first_cyc = -1; last_cyc = -1;
        while ((i < txq.size() || dp_act) && budget < 400) begin
            budget++;
            if (i < txq.size() && txq[i].vld) begin
                HSEL = 1'b1; HTRANS = 2'd2; HWRITE = txq[i].wr;
                HADDR = txq[i].addr; HSIZE = txq[i].size;
            end else begin
                HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0;
            end
            HWDATA = (dp_act && dp.wr) ? dp.wdata : '0;
            @(negedge HCLK);
            if (first_cyc < 0 && i < txq.size() && txq[i].vld) first_cyc = cyc;
            if (dp_act && dp.wr && dp_first) begin
                chk("wr_en", {63'd0, ram_en}, 64'd1);
                chk("wr_we", {56'd0, ram_we}, {56'd0, dp.exp_we});
                chk("wr_a",  {54'd0, ram_a}, {54'd0, dp.addr[12:3]});
                chk("wr_di", ram_di, dp.wdata);
            end
            rdy = HREADY;
            if (!HREADYOUT) begin
                stalls++;
            end else if (dp_act && !dp.wr) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rdata_model", HRDATA, e.model);
                    if (e.chk) chk("rdata_const", HRDATA, e.konst);
                end
                last_cyc = cyc;
            end
            @(posedge HCLK); #1;
            if (rdy) begin
                dp_act = 0;
                if (i < txq.size()) begin
                    t = txq[i];
                    i++;
                    if (t.vld) begin
                        dp = t; dp_act = 1; dp_first = 1;
                        if (t.wr) begin
                            logic [7:0] m;
                            m = ref_mask(t.size, t.addr[2:0]);
                            for (int b = 0; b < 8; b++)
                                if (m[b]) ref_mem[t.addr[12:3]][b*8 +: 8] = t.wdata[b*8 +: 8];
                        end else begin
                            e.model = ref_mem[t.addr[12:3]]; e.chk = t.chk; e.konst = t.exp_rd;
                            sb.push_back(e);
                        end
                    end
                end
            end else begin
                dp_first = 0;
            end
        end
        if (budget >= 400) chk("run_timeout", 64'd1, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        drive_idle();
        txq.delete();
        sb.delete();
        span = (first_cyc >= 0 && last_cyc >= 0) ? last_cyc - first_cyc : -1;
    endtask

    tx_t vec[$];
    int  stalls;
    int  span;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        // Read presented during reset: port must stay quiet anyway.
        HRESETn = 1'b0;
        drive_idle();
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h8;
        @(posedge HCLK); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge HCLK);
            chk("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
            chk("rst_ram_en",    {63'd0, ram_en}, 64'd0);
            chk("rst_ram_we",    {56'd0, ram_we}, 64'd0);
            chk("rst_hresp",     {63'd0, HRESP}, 64'd0);
            @(posedge HCLK); #1;
        end
        ram_clear = 1'b0;
        HRESETn = 1'b1;
        drive_idle();
        @(posedge HCLK); #1;

        // Directed transfers, each separated by an idle cycle.
        vec.push_back(mk(1, 32'h0000_0008, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, '0));
        vec.push_back(mk(1, 32'h0000_0010, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, '0));
        vec.push_back(mk(1, 32'h0000_0013, 3'd0, 64'h0000_0000_5A00_0000, 8'h08, 0, '0));
        vec.push_back(mk(0, 32'h0000_0010, 3'd3, '0, '0, 1, 64'hFFFF_FFFF_5AFF_FFFF));
        vec.push_back(mk(1, 32'h0000_0016, 3'd1, 64'h1234_0000_0000_0000, 8'hC0, 0, '0));
        vec.push_back(mk(0, 32'h0000_0010, 3'd3, '0, '0, 1, 64'h1234_FFFF_5AFF_FFFF));
        vec.push_back(mk(0, 32'h0000_0008, 3'd3, '0, '0, 1, 64'h0123_4567_89AB_CDEF));
        vec.push_back(mk(1, 32'h0000_0018, 3'd3, 64'h0000_0000_0000_0000, 8'hFF, 0, '0));
        vec.push_back(mk(1, 32'h0000_2008, 3'd4, 64'hDEAD_DEAD_DEAD_DEAD, 8'h00, 0, '0));
        vec.push_back(mk(1, 32'h0000_001C, 3'd2, 64'hDEAD_BEEF_0000_0000, 8'hF0, 0, '0));
        vec.push_back(mk(1, 32'h0000_0018, 3'd0, 64'h0000_0000_0000_0077, 8'h01, 0, '0));
        vec.push_back(mk(0, 32'h0000_0018, 3'd3, '0, '0, 1, 64'hDEAD_BEEF_0000_0077));
        vec.push_back(mk(0, 32'hFFFF_E008, 3'd3, '0, '0, 1, 64'h0123_4567_89AB_CDEF));
        for (int k = 0; k < vec.size(); k++) begin
            txq.push_back(vec[k]);
            txq.push_back(idle_tx());
        end
        run_queue(stalls, span);
        chk("table_stalls", 64'(stalls), 64'd0);

        // Read immediately after write to the same word.
        txq.push_back(mk(1, 32'h0000_0020, 3'd3, 64'hA5A5_0F0F_C3C3_9696, 8'hFF, 0, '0));
        txq.push_back(mk(0, 32'h0000_0020, 3'd3, '0, '0, 1, 64'hA5A5_0F0F_C3C3_9696));
        run_queue(stalls, span);
        chk("raw_stalls", 64'(stalls), 64'd1);
        chk("raw_span", 64'(span), 64'd3);

        // Streaming: 16 writes then 16 reads back to back.
        for (int k = 0; k < 16; k++)
            txq.push_back(mk(1, 32'h100 + 32'(k*8), 3'd3,
                             {32'(k) ^ 32'hC0DE_0000, ~32'(k*3)}, 8'hFF, 0, '0));
        for (int k = 0; k < 16; k++)
            txq.push_back(mk(0, 32'h100 + 32'(k*8), 3'd3, '0, '0, 0, '0));
        run_queue(stalls, span);
        chk("stream_stalls", 64'(stalls), 64'd1);

        // HREADY held low by another slave: nothing reaches the RAM.
        hready_low = 1'b1;
        HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b0; HADDR = 32'h8; HSIZE = 3'd3;
        @(negedge HCLK);
        chk("hrdylow_rd_en", {63'd0, ram_en}, 64'd0);
        @(posedge HCLK); #1;
        HWRITE = 1'b1;
        @(negedge HCLK);
        chk("hrdylow_wr_en", {63'd0, ram_en}, 64'd0);
        @(posedge HCLK); #1;
        hready_low = 1'b0;
        drive_idle();
        @(negedge HCLK);
        chk("hrdylow_after_en", {63'd0, ram_en}, 64'd0);
        chk("hrdylow_after_we", {56'd0, ram_we}, 64'd0);
        @(posedge HCLK); #1;

        // Reset landing on a write data phase drops the write.
        HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HADDR = 32'h8; HSIZE = 3'd3;
        @(posedge HCLK); #1;
        drive_idle();
        HRESETn = 1'b0;
        HWDATA = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge HCLK);
        chk("rstwr_we", {56'd0, ram_we}, 64'd0);
        chk("rstwr_en", {63'd0, ram_en}, 64'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        HWDATA = '0;
        @(negedge HCLK);
        chk("rstwr_idle_we", {56'd0, ram_we}, 64'd0);
        @(posedge HCLK); #1;
        txq.push_back(mk(0, 32'h0000_0008, 3'd3, '0, '0, 1, 64'h0123_4567_89AB_CDEF));
        run_queue(stalls, span);
        chk("rstwr_stalls", 64'(stalls), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ahb_ram_1024x64_ctrl.md
# ahb_ram_1024x64_ctrl

AHB-Lite slave front end that sits directly upstream of the 8 KB 1024x64 byte-writable SRAM macro and drives its single CLK/EN/WE[7:0]/A[9:0]/Di/Do port. It converts 64-bit AHB-Lite transfers into RAM accesses with zero-wait-state reads and writes. It inserts exactly one wait state when a read address phase collides with a write data phase on the shared single RAM port.

## Interface
- AW, 13, byte-address width decoded; RAM word address = HADDR[AW-1:3]
- HCLK  in  1  clock; also clocks the RAM macro
- HRESETn  in  1  reset, synchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  32  byte address; only [AW-1:0] used
- HTRANS  in  2  transfer type; only bit 1 (NONSEQ/SEQ) qualifies a transfer
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word, 3 = dword
- HWDATA  in  64  write data, valid in data phase
- HREADY  in  1  bus-wide ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  constant 0 (OKAY)
- HRDATA  out  64  read data = RAM Do
- ram_en  out  1  RAM EN
- ram_we  out  8  RAM byte write enables
- ram_a  out  10  RAM word address
- ram_di  out  64  RAM write data
- ram_do  in  64  RAM read data, valid the cycle after the EN edge

## Operation
- accept = HSEL & HTRANS[1] & HREADY. A read is accept & !HWRITE; a write is accept & HWRITE.
- Byte mask is computed from HSIZE and HADDR[2:0], aligned down to size:
  - size 0: one bit at HADDR[2:0]
  - size 1: 2'b11 << {HADDR[2:1],1'b0}
  - size 2: 4'hF << {HADDR[2],2'b00}
  - size 3: 8'hFF
  - HSIZE > 3: mask 0, write becomes a no-op
- FSM states:
  - IDLE: no data phase pending.
  - RD: read data phase.
  - WR: write data phase; registers wr_addr and wr_mask.
  - WR_HOLD: extended write data phase.
- RAM port priority in any cycle:
  1. In WR, the write commits: ram_en=1, ram_we=wr_mask, ram_a=wr_addr, ram_di=HWDATA.
  2. Otherwise a read address phase drives ram_en=1, ram_we=0, ram_a=HADDR[12:3], combinationally.
  3. Otherwise ram_en=0, ram_we=0.
- Collision: in WR with a read presented (HSEL & HTRANS[1] & !HWRITE):
  - HREADYOUT=0; the write still commits this cycle.
  - Next state is WR_HOLD, where the held read drives the RAM port and HREADYOUT=1.
  - The read is accepted at the end of WR_HOLD, so it goes to RD.
- Write followed by write or idle: no stall. The new write's address is registered while the old write commits.
- HRDATA = ram_do at all times; meaningful only in RD. The full 64 bits are returned and the master selects lanes.
- Address bits above AW-1 are ignored (aliasing). There are no error responses.

## Timing
- Reset (HRESETn=0 at an edge): state IDLE, HREADYOUT=1, HRESP=0, wr_mask=0.
  - While HRESETn=0, ram_en and ram_we are forced to 0 combinationally.
  - A write whose data phase coincides with reset is dropped.
- Read latency: address phase at cycle n, data valid with HREADYOUT=1 in cycle n+1 (zero wait).
- Write: address phase at cycle n; RAM written at the edge ending cycle n+1.
- Read-after-write: read data returned at cycle n+3 instead of n+2.
  - The read returns the just-written data, because the write commits before the read's RAM access.
- Back-to-back reads and back-to-back writes sustain one transfer per cycle.
- HREADY low from another slave: nothing is accepted and no RAM access is made.
- HREADYOUT is 0 only in WR, during a collision.

## Structure
- Package ahb_pkg holds:
  - HTRANS encodings: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - HSIZE encodings.
  - FSM state enum: IDLE, RD, WR, WR_HOLD.
- Sub-module ahb_byte_mask: combinational {HSIZE, HADDR[2:0]} -> 8-bit mask, reused by other 64-bit slaves.

## Test plan
- Reset: HRESETn=0 for 2 cycles -> HREADYOUT=1, ram_en=0, ram_we=0 every cycle.
- Dword write then read:
  - write 0x0008 with 64'h0123_4567_89AB_CDEF -> ram_we=8'hFF, ram_a=1.
  - a later read of 0x0008 -> HRDATA=64'h0123_4567_89AB_CDEF one cycle after its address phase.
- Byte lanes:
  - byte write 8'h5A at 0x0013 onto a word of all-ones -> ram_we=8'h08.
  - read back 64'hFFFF_FFFF_5AFF_FFFF.
  - half write at 0x0016 -> ram_we=8'hC0.
- Read-after-write collision:
  - write 0x0020, then a read of 0x0020 immediately -> HREADYOUT=0 for exactly one cycle.
  - read returns the new data; total 4 cycles.
- Streaming: 16 back-to-back dword writes, then 16 back-to-back reads -> no wait states except one at the write-to-read turnaround; all data matches.
- Reset mid-write: assert HRESETn=0 in a write data phase -> ram_we=0 in that cycle; the location keeps its old value.
